pes_ic_gen: RTL and testbench
=============================

PES_IC_GEN -- requirements
Module: pes_ic_gen

Interface
REQ-001 SHALL have parameter NUM_SRC, default 16, number of interrupt sources (legal 2..32).
REQ-002 SHALL have parameter BUS_W, default 16, command/vector bus width (SHALL be >= 2+2*ID_W).
REQ-003 SHALL have parameter VEC_BASE, default 'h0B0, upper vector field; ID_W = clog2(NUM_SRC).
REQ-004 SHALL have port clk_in  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n_in  input  1  asynchronous active-low reset.
REQ-006 SHALL have port intr_rq  input  NUM_SRC  level-sensitive requests, bit i = source i.
REQ-007 SHALL have port intr_ack_n  input  1  processor acknowledge, active-low one-cycle pulse.
REQ-008 SHALL have port cmd_stb  input  1  one-cycle strobe qualifying cmd_data.
REQ-009 SHALL have port cmd_data  input  BUS_W  processor command word.
REQ-010 SHALL have port intr_out  output  1  interrupt to processor.
REQ-011 SHALL have port bus_out  output  BUS_W  vector, valid while bus_oe=1, else 0.
REQ-012 SHALL have port bus_oe  output  1  high while controller drives vector.
REQ-013 SHALL have port in_service  output  1  high in VEC and SERV states.

Function
REQ-014 Command fields: op=cmd_data[1:0], id=[2+ID_W-1:2], arg=[2+2*ID_W-1:2+ID_W].
REQ-015 op 01 = set mode (arg[1:0]); 10 = set priority level arg for source id; 11 = EOI for id; 00 = mask write (REQ-027).
REQ-016 Modes: 0 fixed (lowest id wins); 1 round-robin (search starts at last granted id+1, wraps NUM_SRC-1 -> 0); 2 programmable (lowest level wins, tie -> lowest id); 3 SHALL behave as mode 0.
REQ-017 FSM states IDLE, REQ, VEC, SERV.
REQ-018 IDLE: if any eligible request, latch winner id, go REQ; intr_out=1 the cycle after the request is sampled.
REQ-019 REQ: intr_out=1; on intr_ack_n=0 go VEC; next cycle intr_out=0, bus_oe=1, bus_out={VEC_BASE, id}.
REQ-020 VEC: hold vector; on second intr_ack_n=0 go SERV, bus_oe=0 next cycle.
REQ-021 SERV: EOI with id == latched id returns to IDLE; mismatched EOI ignored; new arbitration SHALL not start earlier than the cycle after the EOI.
REQ-022 Request dropping after latch SHALL NOT revoke the delivery; latched id delivered.
REQ-023 Config commands accepted in every state; mode/priority changes take effect at next IDLE arbitration; EOI outside SERV ignored.
REQ-024 cmd_stb coincident with intr_ack_n SHALL both be processed in that cycle.
REQ-025 Round-robin pointer SHALL update only on entry to VEC.

Reset
REQ-026 While rst_n_in=0: state IDLE, intr_out=0, bus_oe=0, bus_out=0, in_service=0, mode 0, level[i]=i, RR pointer NUM_SRC-1, mask 0; reset mid-handshake aborts immediately.

Configuration
REQ-027 Macro PES_IC_MASK_EN: defined -> NUM_SRC-bit mask register, op 00 sets mask[id]=arg[0], masked sources ineligible; undefined -> op 00 ignored, all sources eligible.

Structure
REQ-028 Package pes_ic_gen_pkg SHALL hold opcode constants, mode encodings, FSM state type.
REQ-029 Winner selection SHALL be sub-module pes_ic_gen_arb (combinational, requests+mode+levels+pointer -> valid, id).

Verification
REQ-030 Mode 0, intr_rq=0x00AA -> vectors {VEC_BASE,1},3,5,7 in order, each after EOI.
REQ-031 Mode 1, intr_rq=0xFFFF held -> ids 0,1,..,15,0 (wrap) on successive deliveries.
REQ-032 Mode 2, levels 5->0, 3->1, 7->2, rest 3+, intr_rq=0x00FF -> order 5,3,7 then lowest remaining id.
REQ-033 Mismatched EOI id in SERV -> stays SERV, intr_out=0; matching EOI -> next intr_out within 2 cycles.
REQ-034 rst_n_in pulsed low during VEC -> bus_oe, intr_out, in_service 0 asynchronously; mode returns 0.
REQ-035 PES_IC_MASK_EN defined, mask id 2, intr_rq=0x0004 -> intr_out stays 0; unmask -> vector {VEC_BASE,2}.

Source files
------------

// File: rtl/pes_ic_gen_pkg.sv
// Shared constants for the pes_ic_gen interrupt controller: command opcodes,
// arbitration mode encodings and the handshake FSM state type.
package pes_ic_gen_pkg;

  localparam logic [1:0] OpMask  = 2'b00;
  localparam logic [1:0] OpMode  = 2'b01;
  localparam logic [1:0] OpLevel = 2'b10;
  localparam logic [1:0] OpEoi   = 2'b11;

  localparam logic [1:0] ModeFixed    = 2'd0;
  localparam logic [1:0] ModeRr       = 2'd1;
  localparam logic [1:0] ModeProg     = 2'd2;
  localparam logic [1:0] ModeFixedAlt = 2'd3;

  typedef enum logic [1:0] {StIdle, StReq, StVec, StServ} state_e;

endpackage

// File: rtl/pes_ic_gen_arb.sv
// Combinational winner selection: fixed (lowest id), round-robin from ptr_i+1,
// or programmable (lowest level, ties to lowest id). Unknown modes act as fixed.
module pes_ic_gen_arb
  import pes_ic_gen_pkg::*;
#(
  parameter int unsigned NUM_SRC = 16,
  parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]           req_i,
  input  logic [1:0]                   mode_i,
  input  logic [NUM_SRC-1:0][ID_W-1:0] level_i,
  input  logic [ID_W-1:0]              ptr_i,
  output logic                         valid_o,
  output logic [ID_W-1:0]              id_o
);

  logic            found;
  logic [ID_W-1:0] best;
  int unsigned     idx;

  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    found   = 1'b0;
    best    = '0;
    idx     = 0;
    case (mode_i)
      ModeRr: begin
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
          idx = (32'(ptr_i) + 32'd1 + k) % NUM_SRC;
          if (!found && req_i[idx]) begin
            found = 1'b1;
            id_o  = idx[ID_W-1:0];
          end
        end
      end
      ModeProg: begin
        // Strict less-than keeps the lowest id on equal levels.
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if (req_i[i] && (!found || level_i[i] < best)) begin
            found = 1'b1;
            best  = level_i[i];
            id_o  = ID_W'(i);
          end
        end
      end
      default: begin
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
          if (req_i[i]) id_o = ID_W'(i);
        end
      end
    endcase
  end

endmodule

// File: rtl/pes_ic_gen.sv
// Vectored interrupt controller with two-pulse acknowledge and EOI handshake.
// Define PES_IC_MASK_EN to add a per-source mask register written by op 00.
module pes_ic_gen
  import pes_ic_gen_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 16,
  parameter int unsigned BUS_W    = 16,
  parameter int unsigned VEC_BASE = 'h0B0
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [NUM_SRC-1:0] intr_rq,
  input  logic               intr_ack_n,
  input  logic               cmd_stb,
  input  logic [BUS_W-1:0]   cmd_data,
  output logic               intr_out,
  output logic [BUS_W-1:0]   bus_out,
  output logic               bus_oe,
  output logic               in_service
);

  localparam int unsigned ID_W  = $clog2(NUM_SRC);
  localparam int unsigned VHI_W = BUS_W - ID_W;
  localparam logic [VHI_W-1:0] VecHi = VHI_W'(VEC_BASE);

  state_e                      state_q, state_d;
  logic [ID_W-1:0]             id_q, id_d;
  logic [1:0]                  mode_q, mode_d;
  logic [NUM_SRC-1:0][ID_W-1:0] level_q, level_d;
  logic [ID_W-1:0]             ptr_q, ptr_d;
  logic [NUM_SRC-1:0]          eligible;
  logic                        arb_valid;
  logic [ID_W-1:0]             arb_id;

  logic [1:0]      cmd_op;
  logic [ID_W-1:0] cmd_id;
  logic [ID_W-1:0] cmd_arg;

  assign cmd_op  = cmd_data[1:0];
  assign cmd_id  = cmd_data[2 +: ID_W];
  assign cmd_arg = cmd_data[2+ID_W +: ID_W];

  if (BUS_W > 2 + 2 * ID_W) begin : g_unused_cmd
    logic unused_cmd_hi;
    assign unused_cmd_hi = ^cmd_data[BUS_W-1:2+2*ID_W];
  end

`ifdef PES_IC_MASK_EN
  logic [NUM_SRC-1:0] mask_q, mask_d;

  always_comb begin
    mask_d = mask_q;
    if (cmd_stb && cmd_op == OpMask) mask_d[cmd_id] = cmd_arg[0];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) mask_q <= '0;
    else           mask_q <= mask_d;
  end

  assign eligible = intr_rq & ~mask_q;
`else
  assign eligible = intr_rq;
`endif

  pes_ic_gen_arb #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i   (eligible),
    .mode_i  (mode_q),
    .level_i (level_q),
    .ptr_i   (ptr_q),
    .valid_o (arb_valid),
    .id_o    (arb_id)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    mode_d  = mode_q;
    level_d = level_q;
    ptr_d   = ptr_q;

    // Config writes land in registers; the arbiter only sees them next cycle.
    if (cmd_stb) begin
      case (cmd_op)
        OpMode:  mode_d          = cmd_data[2+ID_W +: 2];
        OpLevel: level_d[cmd_id] = cmd_arg;
        default: ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          id_d    = arb_id;
          state_d = StReq;
        end
      end
      StReq: begin
        if (!intr_ack_n) begin
          state_d = StVec;
          ptr_d   = id_q;
        end
      end
      StVec: begin
        if (!intr_ack_n) state_d = StServ;
      end
      StServ: begin
        if (cmd_stb && cmd_op == OpEoi && cmd_id == id_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      id_q    <= '0;
      mode_q  <= ModeFixed;
      ptr_q   <= ID_W'(NUM_SRC - 1);
      for (int i = 0; i < NUM_SRC; i++) level_q[i] <= ID_W'(i);
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      mode_q  <= mode_d;
      ptr_q   <= ptr_d;
      level_q <= level_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  assign intr_out   = (state_q == StReq);
  assign bus_oe     = (state_q == StVec);
  assign bus_out    = bus_oe ? {VecHi, id_q} : '0;
  assign in_service = (state_q == StVec) || (state_q == StServ);

endmodule

// File: tb/tb_pes_ic_gen.sv
// Directed bench for pes_ic_gen: fixed, round-robin and programmable arbitration,
// EOI matching, asynchronous reset mid-handshake and the op 00 mask behaviour.
module tb_pes_ic_gen;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [15:0] intr_rq;
  logic        intr_ack_n;
  logic        cmd_stb;
  logic [15:0] cmd_data;
  logic        intr_out;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic        in_service;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_in = ~clk_in;

  pes_ic_gen #(
    .NUM_SRC  (16),
    .BUS_W    (16),
    .VEC_BASE ('h0B0)
  ) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .intr_rq    (intr_rq),
    .intr_ack_n (intr_ack_n),
    .cmd_stb    (cmd_stb),
    .cmd_data   (cmd_data),
    .intr_out   (intr_out),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .in_service (in_service)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic cmd(input logic [1:0] op, input int id, input int arg);
    cmd_stb  = 1'b1;
    cmd_data = {6'd0, 4'(arg), 4'(id), op};
    tick(1);
    cmd_stb  = 1'b0;
    cmd_data = '0;
  endtask

  task automatic ack();
    intr_ack_n = 1'b0;
    tick(1);
    intr_ack_n = 1'b1;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    intr_rq  = '0;
    tick(2);
    rst_n_in = 1'b1;
    tick(1);
  endtask

  // Full handshake for one expected source; clr drops that request before EOI.
  task automatic deliver(input int id, input bit clr);
    int n = 0;
    while (!intr_out && n < 20) begin
      tick(1);
      n++;
    end
    check($sformatf("intr_out_rise_%0d", id), 32'(intr_out), 32'd1);
    if (intr_out) begin
      ack();
      check($sformatf("vector_%0d", id), 32'(bus_out), 32'h0B00 | 32'(id));
      check($sformatf("vec_oe_%0d", id), 32'({bus_oe, intr_out, in_service}), 32'b101);
      ack();
      check($sformatf("serv_%0d", id), 32'({bus_oe, in_service, bus_out}), 32'h1_0000);
      if (clr) intr_rq[id] = 1'b0;
      cmd(2'b11, id, 0);
      check($sformatf("eoi_%0d", id), 32'(in_service), 32'd0);
    end
  endtask

  initial begin
    intr_ack_n = 1'b1;
    cmd_stb    = 1'b0;
    cmd_data   = '0;
    intr_rq    = '0;
    rst_n_in   = 1'b0;
    tick(2);
    check("reset_outputs", 32'({intr_out, bus_oe, in_service, bus_out}), 32'd0);
    rst_n_in = 1'b1;
    tick(1);

    // Fixed priority: 0x00AA served 1,3,5,7
    intr_rq = 16'h00AA;
    deliver(1, 1'b1);
    deliver(3, 1'b1);
    deliver(5, 1'b1);
    deliver(7, 1'b1);
    tick(3);
    check("fixed_idle", 32'(intr_out), 32'd0);

    // Round-robin with all requests held
    do_reset();
    cmd(2'b01, 0, 1);
    intr_rq = 16'hFFFF;
    for (int i = 0; i < 17; i++) deliver(i % 16, 1'b0);

    // Programmable levels
    do_reset();
    cmd(2'b10, 5, 0);
    cmd(2'b10, 3, 1);
    cmd(2'b10, 7, 2);
    cmd(2'b10, 0, 3);
    cmd(2'b10, 1, 3);
    cmd(2'b10, 2, 3);
    cmd(2'b10, 4, 3);
    cmd(2'b10, 6, 3);
    cmd(2'b01, 0, 2);
    intr_rq = 16'h00FF;
    deliver(5, 1'b1);
    deliver(3, 1'b1);
    deliver(7, 1'b1);
    deliver(0, 1'b1);
    deliver(1, 1'b1);

    // Mismatched EOI is ignored, matching EOI re-arms within two cycles
    do_reset();
    intr_rq = 16'h0010;
    tick(1);
    check("eoi_req", 32'(intr_out), 32'd1);
    ack();
    ack();
    cmd(2'b11, 3, 0);
    check("bad_eoi_hold", 32'({in_service, intr_out}), 32'b10);
    tick(2);
    check("bad_eoi_still", 32'({in_service, intr_out}), 32'b10);
    cmd(2'b11, 4, 0);
    check("good_eoi_idle", 32'(in_service), 32'd0);
    tick(1);
    check("good_eoi_rearm", 32'(intr_out), 32'd1);

    // Asynchronous reset while the vector is on the bus
    do_reset();
    cmd(2'b01, 0, 1);
    intr_rq = 16'h000A;
    tick(1);
    ack();
    check("pre_rst_vec", 32'({bus_oe, bus_out}), 32'h1_0B01);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("async_rst", 32'({bus_oe, intr_out, in_service, bus_out}), 32'd0);
    @(posedge clk_in);
    #3;
    rst_n_in = 1'b1;
    intr_rq  = 16'h000A;
    deliver(1, 1'b0);

    do_reset();
`ifdef PES_IC_MASK_EN
    cmd(2'b00, 2, 1);
    intr_rq = 16'h0004;
    tick(5);
    check("masked_quiet", 32'(intr_out), 32'd0);
    cmd(2'b00, 2, 0);
    deliver(2, 1'b1);
`else
    cmd(2'b00, 2, 1);
    intr_rq = 16'h0004;
    deliver(2, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
